dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Memory-controller responder for the data-cache request port. Accepts one load/store at a time: enable, load/store flag, address, data and byte length. Serialises each request into byte accesses on the 8-bit external RAM/IO bus, assembling loads little-endian. Returns a one-cycle done pulse with the loaded data. Sits between the data cache and the single-byte memory bus, and holds off stores to the UART IO window while the IO buffer is full.

Parameters:
IO_HI, 2'b11, value of address bits [17:16] that selects the IO window
MAX_LEN, 4, maximum byte count per request; larger len is clamped to this value

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rdy  input  1  global ready; low freezes all state
iDC_en  input  1  request valid; held high by the cache until done
iDC_ls  input  1  0 = load, 1 = store
iDC_pc  input  32  byte address
iDC_dt  input  32  store data, little-endian, low len bytes used
iDC_len  input  3  byte count (1, 2, 4 normal)
oDC_done  output  1  one-cycle completion pulse
oDC_dt  output  32  load result, zero-extended; 0 for stores
oDC_wait  output  1  high while a request is in flight
iRAM_dt  input  8  RAM read byte, valid one cycle after its address
oRAM_dt  output  8  RAM write byte
oRAM_a  output  32  RAM byte address
oRAM_wr  output  1  1 = write strobe
iIO_full  input  1  IO buffer full

Behaviour:
- Reset (rst=0, any time, including mid-request): all outputs 0, FSM to IDLE, the in-flight request is abandoned, and no done pulse is issued.
- All outputs are registered. rdy=0 holds every register, and forces oRAM_wr=0 for that cycle.
- FSM states are IDLE, LOAD, STORE, DONE.
- IDLE: on a sampled edge with iDC_en=1, latch ls/pc/dt/len (len clamped to MAX_LEN), clear byte counter i and assembly register, and go to LOAD or STORE. oDC_wait goes high from the next cycle.
- len=0: go directly to DONE with oDC_dt=0 and no bus access.
- LOAD, cycle i (0..L-1): drive oRAM_a=pc+i and oRAM_wr=0. Sample iRAM_dt on the following edge into bits [8i+7:8i].
- LOAD timing: with accept edge E0, the last byte is captured at E(L+1). oDC_done=1 and oDC_dt are valid during the cycle after E(L+1).
- STORE, cycle i: drive oRAM_a=pc+i, oRAM_dt=dt[8i+7:8i] and oRAM_wr=1. With no stalls, done follows in the cycle after E(L).
- IO stall: if pc[17:16]==IO_HI and iIO_full=1, the store cycle is held with oRAM_wr=0 and i is not advanced. It resumes the first cycle iIO_full=0. Loads never stall.
- DONE: oDC_done=1 for exactly one cycle, oDC_wait=0, and the state returns to IDLE. iDC_en is ignored in DONE, because the cache still holds en high there. A new request is accepted no earlier than the following IDLE cycle.
- iDC_en changes while not in IDLE are ignored; the latched request is used.
- Address arithmetic: pc+i wraps modulo 2^32.
- oDC_dt is held from the done cycle until the next request is accepted.

Optional Feature:
MC_IO_GAP_EN: when defined, each IO-window store byte is followed by one forced idle cycle (oRAM_wr=0) before the next byte or DONE. This covers iIO_full lagging the write by one cycle. When undefined, there is no gap and IO stores stall only on iIO_full.

Test Plan:
- Load word: RAM[0x100..0x103]=11,22,33,44; request ls=0, pc=0x100, len=4 -> addresses 0x100..0x103 on consecutive cycles, done in cycle E5, oDC_dt=0x44332211, wr never high.
- Store half: pc=0x200, dt=0xAABBCCDD, len=2 -> wr=1 with (0x200,DD) then (0x201,CC), done in cycle E2, RAM[0x202] untouched.
- IO stall: pc=0x30000, store byte 0x41, iIO_full=1 for 3 cycles -> no wr for 3 cycles, then one write of 0x41 to 0x30000, then done; with MC_IO_GAP_EN, one extra idle cycle before done.
- rdy dropped for 2 cycles mid load word -> address and counter frozen, result still 0x44332211, done delayed by exactly 2 cycles.
- Reset asserted after byte 1 of a store word, then released -> outputs 0, no done pulse; a new load is accepted cleanly on the first IDLE cycle.
- Back-to-back: en held high through done, then a new request the next cycle -> exactly one done per request, no duplicate accept in the DONE cycle.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: data-cache request port plus the byte-wide RAM/IO bus served by dmem_ctrl.
interface dmem_ctrl_if;
    logic        iDC_en;
    logic        iDC_ls;
    logic [31:0] iDC_pc;
    logic [31:0] iDC_dt;
    logic [2:0]  iDC_len;
    logic        oDC_done;
    logic [31:0] oDC_dt;
    logic        oDC_wait;
    logic [7:0]  iRAM_dt;
    logic [7:0]  oRAM_dt;
    logic [31:0] oRAM_a;
    logic        oRAM_wr;
    logic        iIO_full;

    modport slave (
        input  iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len, iRAM_dt, iIO_full,
        output oDC_done, oDC_dt, oDC_wait, oRAM_dt, oRAM_a, oRAM_wr
    );

    modport master (
        output iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len, iRAM_dt, iIO_full,
        input  oDC_done, oDC_dt, oDC_wait, oRAM_dt, oRAM_a, oRAM_wr
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: serialises cache load/store requests into byte accesses on an 8-bit RAM/IO bus.
// Define MC_IO_GAP_EN to force one idle bus cycle after every IO-window store byte.
module dmem_ctrl #(
    parameter logic [1:0] IO_HI   = 2'b11,
    parameter int         MAX_LEN = 4
) (
    input logic        clk,
    input logic        rst,
    input logic        rdy,
    dmem_ctrl_if.slave bus
);
`ifdef MC_IO_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, dt_q, dt_d, asm_q, asm_d, rdt_q, rdt_d, a_q, a_d;
    logic [2:0]  len_q, len_d, i_q, i_d, len_c, n;
    logic [7:0]  wdt_q, wdt_d;
    logic        done_q, done_d, wait_q, wait_d, wr_q, wr_d, io;

    assign len_c = (bus.iDC_len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : bus.iDC_len;
    assign io    = pc_q[17:16] == IO_HI;
    // a store byte only counts as sent in a cycle that actually strobed
    assign n     = i_q + {2'b00, wr_q};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        dt_d    = dt_q;
        len_d   = len_q;
        i_d     = i_q;
        asm_d   = asm_q;
        rdt_d   = rdt_q;
        a_d     = a_q;
        wdt_d   = wdt_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        wr_d    = 1'b0;
        case (state_q)
            IDLE: if (bus.iDC_en) begin
                pc_d  = bus.iDC_pc;
                dt_d  = bus.iDC_dt;
                len_d = len_c;
                i_d   = '0;
                asm_d = '0;
                a_d   = bus.iDC_pc;
                wdt_d = bus.iDC_dt[7:0];
                if (len_c == 3'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdt_d   = '0;
                end else begin
                    state_d = bus.iDC_ls ? STORE : LOAD;
                    wait_d  = 1'b1;
                    wr_d    = bus.iDC_ls && !(bus.iDC_pc[17:16] == IO_HI && bus.iIO_full);
                end
            end
            LOAD: begin
                // read data trails its address by one cycle
                if (i_q != 3'd0) asm_d[{i_q[1:0] - 2'd1, 3'b000} +: 8] = bus.iRAM_dt;
                if (i_q == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    wait_d  = 1'b0;
                    rdt_d   = asm_d;
                end else begin
                    i_d = i_q + 3'd1;
                    a_d = pc_q + 32'(i_q + 3'd1);
                end
            end
            STORE: begin
                if (GAP && wr_q && io) begin
                    i_d = n;
                    a_d = pc_q + 32'(n);
                end else if (n == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    wait_d  = 1'b0;
                    rdt_d   = '0;
                end else begin
                    i_d   = n;
                    a_d   = pc_q + 32'(n);
                    wdt_d = dt_q[{n[1:0], 3'b000} +: 8];
                    wr_d  = !(io && bus.iIO_full);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            dt_q    <= '0;
            len_q   <= '0;
            i_q     <= '0;
            asm_q   <= '0;
            rdt_q   <= '0;
            a_q     <= '0;
            wdt_q   <= '0;
            wait_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dt_q    <= dt_d;
            len_q   <= len_d;
            i_q     <= i_d;
            asm_q   <= asm_d;
            rdt_q   <= rdt_d;
            a_q     <= a_d;
            wdt_q   <= wdt_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.oDC_done = done_q;
    assign bus.oDC_dt   = rdt_q;
    assign bus.oDC_wait = wait_q;
    assign bus.oRAM_dt  = wdt_q;
    assign bus.oRAM_a   = a_q;
    assign bus.oRAM_wr  = wr_q & rdy;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized scoreboard bench for dmem_ctrl with a byte-array memory reference model.
module tb_dmem_ctrl;
`ifdef MC_IO_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    dmem_ctrl_if bus();
    dmem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {logic [31:0] dt; int lat; int acc;} done_t;
    typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;

    done_t sb[$];
    wr_t   wq[$];
    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    int cyc = 0, n_tests = 0, n_fail = 0;
    done_t e;
    wr_t   w;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5a;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // external RAM: one-cycle read latency, frozen together with the controller when rdy is low
    always @(posedge clk) if (rdy) begin
        bus.iRAM_dt <= ram_mem.exists(bus.oRAM_a) ? ram_mem[bus.oRAM_a] : dflt(bus.oRAM_a);
        if (bus.oRAM_wr) ram_mem[bus.oRAM_a] = bus.oRAM_dt;
    end

    always @(negedge clk) if (rst) begin
        if (bus.oDC_done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: actual done dt=%0h required no done (cycle %0d)", bus.oDC_dt, cyc);
            end else begin
                e = sb.pop_front();
                chk("done_dt", 80'(bus.oDC_dt), 80'(e.dt));
                chk("done_latency", 80'(cyc - e.acc), 80'(e.lat));
                chk("done_wait_low", 80'(bus.oDC_wait), 80'(0));
            end
        end
        if (bus.oRAM_wr) begin
            if (wq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL write_unexpected: actual a=%0h d=%0h required no write", bus.oRAM_a, bus.oRAM_dt);
            end else begin
                w = wq.pop_front();
                chk("write_addr", 80'(bus.oRAM_a), 80'(w.a));
                chk("write_data", 80'(bus.oRAM_dt), 80'(w.d));
            end
        end
    end

    // Issues one request from an IDLE cycle and holds en until done; returns in the following IDLE cycle.
    task automatic do_req(input logic ls, input logic [31:0] pc, input logic [31:0] dt,
                          input logic [2:0] len, input int full_n, input int rdy_n);
        int L, lat;
        bit io, got;
        logic [31:0] ex;
        L  = (len > 3'd4) ? 4 : int'(len);
        io = pc[17:16] == 2'b11;
        ex = '0;
        if (L == 0) lat = 0;
        else if (ls) lat = L + (io ? full_n : 0) + ((GAP != 0 && io) ? L : 0) + rdy_n;
        else lat = L + 1 + rdy_n;
        for (int i = 0; i < L; i++) begin
            if (ls) begin
                wq.push_back('{a: pc + 32'(i), d: dt[8*i +: 8]});
                ref_mem[pc + 32'(i)] = dt[8*i +: 8];
            end else ex[8*i +: 8] = ref_rd(pc + 32'(i));
        end
        sb.push_back('{dt: ex, lat: lat, acc: cyc + 1});
        bus.iDC_en   = 1'b1;
        bus.iDC_ls   = ls;
        bus.iDC_pc   = pc;
        bus.iDC_dt   = dt;
        bus.iDC_len  = len;
        bus.iIO_full = full_n > 0;
        step;
        chk("wait_busy", 80'(bus.oDC_wait), 80'(L != 0));
        got = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (bus.oDC_done) begin
                got = 1'b1;
                break;
            end
            rdy          = !(k >= 1 && k < 1 + rdy_n);
            bus.iIO_full = (k + 1) < full_n;
            bus.iDC_pc   = $urandom;
            bus.iDC_dt   = $urandom;
            bus.iDC_ls   = 1'($urandom);
            bus.iDC_len  = 3'($urandom);
            step;
        end
        rdy          = 1'b1;
        bus.iIO_full = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: actual no done in 80 cycles required done (pc=%0h)", pc);
            sb.delete();
            wq.delete();
        end
        step;
        bus.iDC_en = 1'b0;
    endtask

    initial begin
        bus.iDC_en   = 1'b0;
        bus.iDC_ls   = 1'b0;
        bus.iDC_pc   = '0;
        bus.iDC_dt   = '0;
        bus.iDC_len  = '0;
        bus.iIO_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ram_mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
            ref_mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
        end
        repeat (3) step;
        chk("reset_dc", {bus.oDC_done, bus.oDC_wait, bus.oDC_dt}, 80'(0));
        chk("reset_ram", {bus.oRAM_wr, bus.oRAM_dt, bus.oRAM_a}, 80'(0));
        rst = 1'b1;
        step;

        do_req(1'b0, 32'h100, 32'h0, 3'd4, 0, 0);
        do_req(1'b1, 32'h200, 32'hAABBCCDD, 3'd2, 0, 0);
        do_req(1'b0, 32'h200, 32'h0, 3'd4, 0, 0);
        do_req(1'b1, 32'h30000, 32'h41, 3'd1, 3, 0);
        do_req(1'b0, 32'h100, 32'h0, 3'd4, 0, 2);
        do_req(1'b1, 32'h104, 32'h01020304, 3'd7, 0, 0);
        do_req(1'b0, 32'h104, 32'h0, 3'd0, 0, 0);
        do_req(1'b0, 32'hFFFFFFFE, 32'h0, 3'd4, 2, 0);

        // reset in the middle of a store word, after its second byte
        bus.iDC_en  = 1'b1;
        bus.iDC_ls  = 1'b1;
        bus.iDC_pc  = 32'h180;
        bus.iDC_dt  = 32'h55667788;
        bus.iDC_len = 3'd4;
        wq.push_back('{a: 32'h180, d: 8'h88});
        wq.push_back('{a: 32'h181, d: 8'h77});
        wq.push_back('{a: 32'h182, d: 8'h66});
        wq.push_back('{a: 32'h183, d: 8'h55});
        ref_mem[32'h180] = 8'h88;
        ref_mem[32'h181] = 8'h77;
        step;
        step;
        step;
        rst = 1'b0;
        #1;
        wq.delete();
        chk("midreset_dc", {bus.oDC_done, bus.oDC_wait, bus.oDC_dt}, 80'(0));
        chk("midreset_ram", {bus.oRAM_wr, bus.oRAM_dt, bus.oRAM_a}, 80'(0));
        step;
        rst = 1'b1;
        do_req(1'b0, 32'h180, 32'h0, 3'd4, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] pc;
            logic [2:0]  len;
            logic        ls;
            int sel, L, fn, rn;
            sel = $urandom_range(0, 3);
            pc  = (sel == 0) ? 32'h100 + $urandom_range(0, 60) :
                  (sel == 1) ? 32'h30000 + $urandom_range(0, 60) :
                  (sel == 2) ? 32'hFFFFFFFC + $urandom_range(0, 3) : $urandom;
            ls  = 1'($urandom);
            len = 3'($urandom);
            L   = (len > 3'd4) ? 4 : int'(len);
            fn  = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : 0;
            rn  = (fn == 0 && ((!ls && L >= 1) || (ls && L >= 2))) ? $urandom_range(0, 2) : 0;
            if ($urandom_range(0, 3) == 0) step;
            do_req(ls, pc, $urandom, len, fn, rn);
        end

        repeat (5) step;
        chk("scoreboard_drained", 80'(sb.size()), 80'(0));
        chk("writes_drained", 80'(wq.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog");
    end
endmodule
